// File: rtl/eth_pon_pkg.sv
// Shared types and constants for the XG-PON TX burst arbiter slice.
package eth_pon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic SRC_LB   = 1'b0;
  localparam logic SRC_PRBS = 1'b1;
  localparam int   TMR_W    = 32;

endpackage

// File: rtl/burst_window_timer.sv
// Burst window timer: shadowed length/period, period counter and registered
// window flag that gates new frame grants.
module burst_window_timer
  import eth_pon_pkg::*;
(
  input  logic             tx_axis_usrclk,
  input  logic             reset_in,
  input  logic             enable,
  input  logic [TMR_W-1:0] burst_length,
  input  logic [TMR_W-1:0] burst_period,
  output logic             window_open
);

  logic [TMR_W-1:0] period_cnt_q, period_cnt_d;
  logic [TMR_W-1:0] len_q, len_d;
  logic [TMR_W-1:0] per_q, per_d;
  logic             en_q, en_d;
  logic             win_q, win_d;
  logic             first_s, wrap_s;
  logic [TMR_W-1:0] len_use_s, per_use_s;

  // On the first enabled cycle the shadows are stale, so the live inputs decide.
  always_comb begin
    first_s   = enable & ~en_q;
    len_use_s = first_s ? burst_length : len_q;
    per_use_s = first_s ? burst_period : per_q;
    wrap_s    = (per_use_s == {TMR_W{1'b0}}) ||
                (period_cnt_q >= (per_use_s - {{(TMR_W-1){1'b0}}, 1'b1}));
    en_d         = enable;
    period_cnt_d = period_cnt_q;
    len_d        = len_q;
    per_d        = per_q;
    win_d        = 1'b0;
    if (!enable) begin
      period_cnt_d = {TMR_W{1'b0}};
      win_d        = 1'b0;
    end else begin
      period_cnt_d = wrap_s ? {TMR_W{1'b0}} : (period_cnt_q + {{(TMR_W-1){1'b0}}, 1'b1});
      if (wrap_s || first_s) begin
        len_d = burst_length;
        per_d = burst_period;
      end else begin
        len_d = len_q;
        per_d = per_q;
      end
      win_d = (per_use_s == {TMR_W{1'b0}}) || (len_use_s >= per_use_s) ||
              (period_cnt_q < len_use_s);
    end
  end

  // Timer state registers.
  always_ff @(posedge tx_axis_usrclk or posedge reset_in) begin
    if (reset_in) begin
      period_cnt_q <= {TMR_W{1'b0}};
      len_q        <= {TMR_W{1'b0}};
      per_q        <= {TMR_W{1'b0}};
      en_q         <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      len_q        <= len_d;
      per_q        <= per_d;
      en_q         <= en_d;
      win_q        <= win_d;
    end
  end

  assign window_open = win_q;

endmodule

// File: rtl/eth_tx_burst_arbiter.sv
// Frame-atomic two-source arbiter for the 10G MAC TX AXI-stream port; new
// frames start only inside the burst window, sources alternate on contention.
module eth_tx_burst_arbiter
  import eth_pon_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              tx_axis_usrclk,
  input  logic              reset_in,
  input  logic              enable,
  input  logic [31:0]       burst_length,
  input  logic [31:0]       burst_period,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  input  logic              s0_tuser,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  input  logic              s1_tuser,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic              window_open,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  frame_cnt_0,
  output logic [CNT_W-1:0]  frame_cnt_1
);

  arb_state_t       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] frame_cnt_0_q, frame_cnt_0_d;
  logic [CNT_W-1:0] frame_cnt_1_q, frame_cnt_1_d;
  logic             window_open_s, tlast_hs_s, cand0_s, cand1_s;

  burst_window_timer u_timer (
    .tx_axis_usrclk (tx_axis_usrclk),
    .reset_in       (reset_in),
    .enable         (enable),
    .burst_length   (burst_length),
    .burst_period   (burst_period),
    .window_open    (window_open_s)
  );

  // Zero-latency passthrough of the owning source; everything reads 0 when idle.
  always_comb begin
    m_tdata   = {DATA_W{1'b0}};
    m_tkeep   = {KEEP_W{1'b0}};
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state_q)
      GRANT0: begin
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        m_tuser   = s0_tuser;
        s0_tready = m_tready;
      end
      GRANT1: begin
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        m_tuser   = s1_tuser;
        s1_tready = m_tready;
      end
      default: begin
        m_tvalid = 1'b0;
      end
    endcase
  end

  assign tlast_hs_s = m_tvalid & m_tready & m_tlast;
  assign cand0_s    = s0_tvalid & window_open_s & enable;
  assign cand1_s    = s1_tvalid & window_open_s & enable;

  // Arbitration happens only between frames, so a started frame always completes.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    frame_cnt_0_d = frame_cnt_0_q;
    frame_cnt_1_d = frame_cnt_1_q;
    if ((state_q == IDLE) || tlast_hs_s) begin
      if (cand0_s && (!cand1_s || (last_grant_q == SRC_PRBS))) begin
        state_d      = GRANT0;
        grant_d      = 2'b01;
        last_grant_d = SRC_LB;
      end else if (cand1_s) begin
        state_d      = GRANT1;
        grant_d      = 2'b10;
        last_grant_d = SRC_PRBS;
      end else begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    end else begin
      state_d = state_q;
    end
    if (tlast_hs_s && (state_q == GRANT0)) begin
      frame_cnt_0_d = frame_cnt_0_q + CNT_W'(1);
    end else if (tlast_hs_s && (state_q == GRANT1)) begin
      frame_cnt_1_d = frame_cnt_1_q + CNT_W'(1);
    end else begin
      frame_cnt_0_d = frame_cnt_0_q;
    end
  end

  // Arbiter state, round-robin pointer and frame counters.
  always_ff @(posedge tx_axis_usrclk or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_grant_q  <= SRC_PRBS;
      frame_cnt_0_q <= {CNT_W{1'b0}};
      frame_cnt_1_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      frame_cnt_0_q <= frame_cnt_0_d;
      frame_cnt_1_q <= frame_cnt_1_d;
    end
  end

  assign window_open = window_open_s;
  assign grant       = grant_q;
  assign frame_cnt_0 = frame_cnt_0_q;
  assign frame_cnt_1 = frame_cnt_1_q;

endmodule

// File: tb/tb_eth_tx_burst_arbiter.sv
// Randomized scoreboard bench for eth_tx_burst_arbiter with a behavioural
// model of the burst window and frame-level round-robin arbitration.
module tb_eth_tx_burst_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] burst_length = 32'd0;
  logic [31:0] burst_period = 32'd0;
  logic        m_tready = 1'b0;
  logic        s0_tready, s1_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tuser, window_open;
  logic [1:0]  grant;
  logic [15:0] frame_cnt_0, frame_cnt_1;

  beat_t stim[2][$];
  beat_t exp_q[2][$];
  logic  sv_valid[2];
  beat_t sv_beat[2];
  bit    hs[2];
  bit    src_rst = 1'b0;
  int    ready_pct = 100;
  int    gap_pct = 0;
  int    tests = 0;
  int    fails = 0;

  // reference model state
  longint mdl_pos, mdl_len, mdl_per;
  bit     mdl_win, mdl_en_prev;
  int     mdl_owner, mdl_last, fb0;
  int     mdl_cnt[2];

  always #5 clk = ~clk;

  eth_tx_burst_arbiter dut (
    .tx_axis_usrclk (clk),
    .reset_in       (reset_in),
    .enable         (enable),
    .burst_length   (burst_length),
    .burst_period   (burst_period),
    .s0_tdata       (sv_beat[0].data),
    .s0_tkeep       (sv_beat[0].keep),
    .s0_tvalid      (sv_valid[0]),
    .s0_tlast       (sv_beat[0].last),
    .s0_tuser       (sv_beat[0].user),
    .s0_tready      (s0_tready),
    .s1_tdata       (sv_beat[1].data),
    .s1_tkeep       (sv_beat[1].keep),
    .s1_tvalid      (sv_valid[1]),
    .s1_tlast       (sv_beat[1].last),
    .s1_tuser       (sv_beat[1].user),
    .s1_tready      (s1_tready),
    .m_tdata        (m_tdata),
    .m_tkeep        (m_tkeep),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tuser        (m_tuser),
    .m_tready       (m_tready),
    .window_open    (window_open),
    .grant          (grant),
    .frame_cnt_0    (frame_cnt_0),
    .frame_cnt_1    (frame_cnt_1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic gen_frame(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom_range(15));
      b.last = (i == len - 1);
      b.user = 1'($urandom_range(1));
      stim[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic model_reset();
    mdl_pos = 0; mdl_len = 0; mdl_per = 0;
    mdl_win = 1'b0; mdl_en_prev = 1'b0;
    mdl_owner = -1; mdl_last = 1; fb0 = 0;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
  endtask

  // Source drivers: hold a presented beat until it handshakes, otherwise offer the next one.
  initial begin
    sv_valid[0] = 1'b0; sv_valid[1] = 1'b0;
    sv_beat[0] = '0; sv_beat[1] = '0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (src_rst) begin
          stim[s].delete();
          sv_valid[s] = 1'b0;
          sv_beat[s] = '0;
        end else begin
          beat_t tmp;
          if (hs[s] && stim[s].size() != 0) tmp = stim[s].pop_front();
          if (!(sv_valid[s] && !hs[s]))
            sv_valid[s] = (stim[s].size() != 0) && ($urandom_range(99) >= gap_pct);
          sv_beat[s] = sv_valid[s] ? stim[s][0] : '0;
        end
      end
      m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (reset_in) begin
      model_reset();
      hs[0] = 1'b0; hs[1] = 1'b0;
    end else begin
      bit eval, c0, c1, first, nw;
      int nxt;
      longint lu, pu;
      beat_t e;
      chk("grant", grant, (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00);
      chk("window_open", window_open, mdl_win);
      chk("s0_tready", s0_tready, (mdl_owner == 0) && m_tready);
      chk("s1_tready", s1_tready, (mdl_owner == 1) && m_tready);
      eval = (mdl_owner < 0);
      if (mdl_owner < 0) begin
        chk("idle_m", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, 64'd0);
      end else begin
        chk("m_tvalid", m_tvalid, sv_valid[mdl_owner]);
        if (sv_valid[mdl_owner] && m_tready) begin
          if (exp_q[mdl_owner].size() == 0) begin
            chk("beat_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q[mdl_owner].pop_front();
            chk(mdl_owner == 0 ? "beat_s0" : "beat_s1", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
          end
          if (mdl_owner == 0) fb0 = sv_beat[0].last ? 0 : fb0 + 1;
          if (sv_beat[mdl_owner].last) begin
            mdl_cnt[mdl_owner]++;
            eval = 1'b1;
          end
        end
      end
      if (eval) begin
        c0 = sv_valid[0] && mdl_win && enable;
        c1 = sv_valid[1] && mdl_win && enable;
        if (c0 && c1) nxt = (mdl_last == 0) ? 1 : 0;
        else if (c0) nxt = 0;
        else if (c1) nxt = 1;
        else nxt = -1;
        if (nxt >= 0) mdl_last = nxt;
        mdl_owner = nxt;
      end
      // window: position within the latched period, one cycle of lag on the flag
      first = enable && !mdl_en_prev;
      lu = first ? longint'({32'd0, burst_length}) : mdl_len;
      pu = first ? longint'({32'd0, burst_period}) : mdl_per;
      if (!enable) begin
        mdl_pos = 0;
        mdl_win = 1'b0;
      end else begin
        nw = (pu == 0) || (lu >= pu) || (mdl_pos < lu);
        if (pu == 0 || mdl_pos + 1 >= pu) mdl_pos = 0;
        else mdl_pos = mdl_pos + 1;
        if (mdl_pos == 0 || first) begin
          mdl_len = longint'({32'd0, burst_length});
          mdl_per = longint'({32'd0, burst_period});
        end
        mdl_win = nw;
      end
      mdl_en_prev = enable;
      hs[0] = sv_valid[0] && s0_tready;
      hs[1] = sv_valid[1] && s1_tready;
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((stim[0].size() + stim[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(n < budget), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset_in = 1'b1;
    src_rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk);
    @(posedge clk); #2;
    reset_in = 1'b0;
    src_rst = 1'b0;
  endtask

  initial begin
    int n, wcnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_window", window_open, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_treadys", {s0_tready, s1_tready}, 2'b00);
    chk("rst_cnts", {frame_cnt_0, frame_cnt_1}, 32'd0);
    #1 reset_in = 1'b0;

    // always-open window, s0 back-to-back frames
    @(posedge clk); #1;
    enable = 1'b1;
    gen_frame(0, 4); gen_frame(0, 4); gen_frame(0, 4);
    wait_drain("p1", 200);
    chk("p1_frame_cnt_0", frame_cnt_0, 16'd3);

    // contention: strict alternation
    pulse_reset();
    for (int i = 0; i < 4; i++) begin gen_frame(0, 2); gen_frame(1, 2); end
    wait_drain("p2", 200);
    chk("p2_frame_cnt_0", frame_cnt_0, 16'd4);
    chk("p2_frame_cnt_1", frame_cnt_1, 16'd4);

    // bursty window P=100 L=20, length change mid-period
    burst_period = 32'd100;
    burst_length = 32'd20;
    pulse_reset();
    for (int i = 0; i < 12; i++) gen_frame(1, 8);
    n = 0;
    while (mdl_pos != 30 && n < 300) begin @(posedge clk); #1; n++; end
    chk("p3_wait_pos30", 64'(n < 300), 64'd1);
    burst_length = 32'd50;
    n = 0;
    while (mdl_pos != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("p3_wait_wrap", 64'(n < 300), 64'd1);
    wcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (window_open) wcnt++;
    end
    chk("p3_window_cycles_L50", wcnt, 50);
    wait_drain("p3", 3000);
    chk("p3_frame_cnt_1", frame_cnt_1, 16'd12);

    // random backpressure and source gaps
    burst_period = 32'd0;
    burst_length = 32'd0;
    pulse_reset();
    ready_pct = 50;
    gap_pct = 20;
    for (int i = 0; i < 10; i++) gen_frame(0, $urandom_range(1, 6));
    wait_drain("p4", 2000);
    chk("p4_frame_cnt_0", frame_cnt_0, 16'd10);

    // fully random: enable toggling, window reprogramming, both sources
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < 3) enable = ~enable;
      if ($urandom_range(99) < 2) begin
        burst_period = 32'($urandom_range(10));
        burst_length = 32'($urandom_range(12));
      end
      for (int s = 0; s < 2; s++)
        if (stim[s].size() < 4) gen_frame(s, $urandom_range(1, 5));
    end
    enable = 1'b1;
    gap_pct = 0;
    burst_period = 32'd0;
    burst_length = 32'd0;
    wait_drain("p5", 5000);
    chk("p5_frame_cnt_0", frame_cnt_0, 16'(mdl_cnt[0]));
    chk("p5_frame_cnt_1", frame_cnt_1, 16'(mdl_cnt[1]));

    // reset in the middle of a frame
    ready_pct = 100;
    pulse_reset();
    gen_frame(0, 8);
    n = 0;
    while (fb0 != 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("p6_wait_beat3", 64'(n < 50), 64'd1);
    chk("p6_pre_reset_valid", m_tvalid, 1'b1);
    #1 reset_in = 1'b1;
    #1;
    chk("p6_reset_m_tvalid", m_tvalid, 1'b0);
    chk("p6_reset_s0_tready", s0_tready, 1'b0);
    chk("p6_reset_grant", grant, 2'b00);
    src_rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk);
    @(posedge clk); #2;
    reset_in = 1'b0;
    src_rst = 1'b0;
    @(posedge clk); #1;
    gen_frame(0, 2);
    gen_frame(1, 2);
    n = 0;
    while (grant == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
    chk("p6_first_grant_s0", grant, 2'b01);
    wait_drain("p6", 200);
    chk("p6_frame_cnts", {frame_cnt_0, frame_cnt_1}, {16'd1, 16'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
